accel_mem_cmd_packer: RTL and testbench

Accelerator-side initiator that issues the bridge's packed 128-bit command word. It accepts one scalar load/store request at a time from accelerator datapath logic, packs address, data and size flags into the 128-bit word, and drives it as an Avalon-MM master with waitrequest/readdatavalid handshaking. It returns size-masked (optionally sign-extended) load data plus a completion or error response. One transaction is in flight at a time.

---
 rtl/accel_mem_pkg.sv | 59 +++++
 rtl/accel_load_extend.sv | 42 ++++
 rtl/accel_mem_cmd_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_accel_mem_cmd_packer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_mem_pkg.sv
// -----------------------------------------------------------------------------
// accel_mem_pkg
//
// Shared definitions for the accelerator memory command path:
//   - access size encodings carried on req_size
//   - bit positions inside the 128-bit packed command word
//   - FSM state constants used by accel_mem_cmd_packer
//   - helpers for the misalignment rule and command-word packing
// -----------------------------------------------------------------------------
package accel_mem_pkg;

  // Access size encodings.
  localparam logic [1:0] SZ8  = 2'd0;
  localparam logic [1:0] SZ16 = 2'd1;
  localparam logic [1:0] SZ32 = 2'd2;
  localparam logic [1:0] SZ64 = 2'd3;

  // Packed command word layout. Bits 31 and 127:99 are always zero.
  localparam int CMD_W    = 128;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 31;
  localparam int DATA_LSB = 32;
  localparam int DATA_W   = 64;
  localparam int FLAG8    = 96;
  localparam int FLAG16   = 97;
  localparam int FLAG64   = 98;

  // FSM states of the command packer.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CMD     = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  // An access is misaligned when it would cross an 8-byte boundary.
  // Four bits are enough: the worst case is 7 + 8 = 15.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [1:0] size);
    logic [3:0] span;
    span = 4'd1 << size;
    return (({1'b0, addr_lo} + span) > 4'd8);
  endfunction

  // Build the command word. Store data goes out unshifted; the bridge
  // does the byte-lane steering. 32-bit accesses set none of the flags.
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [1:0]        size);
    logic [CMD_W-1:0] w;
    w = '0;
    w[ADDR_LSB +: ADDR_W] = addr;
    w[DATA_LSB +: DATA_W] = wdata;
    w[FLAG8]              = (size == SZ8);
    w[FLAG16]             = (size == SZ16);
    w[FLAG64]             = (size == SZ64);
    return w;
  endfunction

endpackage

// File: rtl/accel_load_extend.sv
// -----------------------------------------------------------------------------
// accel_load_extend
//
// Combinational load-data formatter: keeps the low 8/16/32/64 bits of the
// incoming data according to the access size and either zero-fills or
// sign-extends the remaining upper bits.
//
// Ports:
//   data_i   [63:0]  raw load data, already right-aligned
//   size_i   [1:0]   access size (SZ8/SZ16/SZ32/SZ64)
//   signed_i         1 = replicate the top bit of the field upward
//   data_o   [63:0]  formatted load result
// -----------------------------------------------------------------------------
module accel_load_extend
  import accel_mem_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [63:0] data_o
);

  logic ext8;
  logic ext16;
  logic ext32;

  // Fill bit for each size: the field's top bit when signed, else zero.
  assign ext8  = signed_i & data_i[7];
  assign ext16 = signed_i & data_i[15];
  assign ext32 = signed_i & data_i[31];

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ8:     data_o = {{56{ext8}},  data_i[7:0]};
      SZ16:    data_o = {{48{ext16}}, data_i[15:0]};
      SZ32:    data_o = {{32{ext32}}, data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/accel_mem_cmd_packer.sv
// -----------------------------------------------------------------------------
// accel_mem_cmd_packer
//
// Accelerator-side Avalon-MM initiator. Takes one scalar load/store at a
// time, packs it into the bridge's 128-bit command word, runs the bus
// handshake and returns a registered one-cycle response.
//
// Handshakes:
//   Request side: a request transfers on a rising edge where req_valid and
//   req_ready are both high; the request fields are sampled only then.
//   Bus side: a command stays asserted with stable writedata until a cycle
//   in which waitrequest is low; that cycle's edge is the acceptance.
//   readdatavalid is honoured only while a load is outstanding (in the
//   acceptance cycle itself or afterwards in RD_WAIT).
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid / req_ready           request handshake
//   req_write, req_addr, req_wdata  store flag, byte address, store data
//   req_size, req_signed            access size, sign-extend loads
//   resp_valid, resp_err,
//   resp_rdata                      registered completion pulse and data
//   address_to_bridge               tied to 0
//   writedata_to_bridge             packed command word
//   write_to_bridge, read_to_bridge Avalon strobes
//   readdata_from_bridge            load data (bits 63:0 used)
//   waitrequest_from_bridge,
//   readdatavalid_from_bridge       Avalon flow control
// -----------------------------------------------------------------------------
module accel_mem_cmd_packer
  import accel_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [30:0]  req_addr,
  input  logic [63:0]  req_wdata,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [63:0]  resp_rdata,
  output logic         address_to_bridge,
  output logic [127:0] writedata_to_bridge,
  output logic         write_to_bridge,
  output logic         read_to_bridge,
  input  logic [127:0] readdata_from_bridge,
  input  logic         waitrequest_from_bridge,
  input  logic         readdatavalid_from_bridge
);

  localparam logic [CNT_W:0] TO_LIMIT = TIMEOUT_CYCLES[CNT_W:0];

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               is_store_q, is_store_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic               write_q, write_d;
  logic               read_q, read_d;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W:0]     cnt_nxt;
  logic               timeout_hit;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [63:0]        resp_rdata_q, resp_rdata_d;
  logic [63:0]        load_ext;
  logic               accept;
  logic               unused_rd_hi;

  // The bridge already shifts read data down; only the low 64 bits matter.
  assign unused_rd_hi = ^readdata_from_bridge[127:64];

  accel_load_extend u_load_extend (
    .data_i   (readdata_from_bridge[63:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_ext)
  );

  assign accept = req_valid & ready_q;

  // The counter is loaded with 1 at acceptance, so it holds the number of
  // cycles elapsed since the request was taken. Aborting when the next value
  // reaches TIMEOUT_CYCLES lands the error response exactly TIMEOUT_CYCLES
  // cycles after acceptance. A completing handshake in the same cycle wins.
  assign cnt_nxt     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_nxt >= TO_LIMIT);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    read_d       = read_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_misaligned(req_addr[2:0], req_size)) begin
            // No bus cycle; report the error straight away.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ST_CMD;
            cmd_d      = pack_cmd(req_addr, req_wdata, req_size);
            is_store_d = req_write;
            size_d     = req_size;
            signed_d   = req_signed;
            write_d    = req_write;
            read_d     = ~req_write;
            cnt_d      = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_CMD: begin
        cnt_d = cnt_nxt[CNT_W-1:0];
        if (!waitrequest_from_bridge) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          if (is_store_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end else if (readdatavalid_from_bridge) begin
            // Zero-latency slave: data comes back with the acceptance.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else if (timeout_hit) begin
          write_d      = 1'b0;
          read_d       = 1'b0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        cnt_d = cnt_nxt[CNT_W-1:0];
        if (readdatavalid_from_bridge) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end else if (timeout_hit) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        // The response registers are high during this single cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      is_store_q   <= 1'b0;
      size_q       <= SZ8;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      read_q       <= read_d;
      // Registered copy of (state == IDLE); held low while in reset so
      // every output reads 0 until the first clock after release.
      ready_q      <= (state_d == ST_IDLE);
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready           = ready_q;
  assign resp_valid          = resp_valid_q;
  assign resp_err            = resp_err_q;
  assign resp_rdata          = resp_rdata_q;
  assign address_to_bridge   = 1'b0;
  assign writedata_to_bridge = cmd_q;
  assign write_to_bridge     = write_q;
  assign read_to_bridge      = read_q;

endmodule

// File: tb/tb_accel_mem_cmd_packer.sv
// -----------------------------------------------------------------------------
// tb_accel_mem_cmd_packer
//
// Directed and randomized transactions against a behavioural model of the
// command packer, with an Avalon slave whose wait states and read latency
// are set per transaction.
// -----------------------------------------------------------------------------
module tb_accel_mem_cmd_packer;

  localparam int TB_TIMEOUT = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         reset = 1'b1;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [30:0]  req_addr = '0;
  logic [63:0]  req_wdata = '0;
  logic [1:0]   req_size = '0;
  logic         req_signed = 1'b0;
  logic         resp_valid;
  logic         resp_err;
  logic [63:0]  resp_rdata;
  logic         address_to_bridge;
  logic [127:0] writedata_to_bridge;
  logic         write_to_bridge;
  logic         read_to_bridge;
  logic [127:0] readdata_from_bridge;
  logic         waitrequest_from_bridge = 1'b0;
  logic         readdatavalid_from_bridge = 1'b0;

  accel_mem_cmd_packer #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .CNT_W          (4)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_write                 (req_write),
    .req_addr                  (req_addr),
    .req_wdata                 (req_wdata),
    .req_size                  (req_size),
    .req_signed                (req_signed),
    .resp_valid                (resp_valid),
    .resp_err                  (resp_err),
    .resp_rdata                (resp_rdata),
    .address_to_bridge         (address_to_bridge),
    .writedata_to_bridge       (writedata_to_bridge),
    .write_to_bridge           (write_to_bridge),
    .read_to_bridge            (read_to_bridge),
    .readdata_from_bridge      (readdata_from_bridge),
    .waitrequest_from_bridge   (waitrequest_from_bridge),
    .readdatavalid_from_bridge (readdatavalid_from_bridge)
  );

  // ---------------------------------------------------------------- slave model
  int           knob_wait = 0;     // waitrequest cycles before acceptance
  int           knob_lat = 1;      // read latency after acceptance (0 = same cycle)
  bit           knob_never = 1'b0; // never return read data
  bit           inject_rdv = 1'b0; // stray readdatavalid pulse
  logic [127:0] rd_word = '0;
  int           hold_cnt = 0;
  int           rd_cd = 0;
  int           n_accept = 0;
  bit           prev_cmd = 1'b0;
  bit           prev_rd = 1'b0;

  assign readdata_from_bridge = rd_word;

  // Outputs are updated on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_cnt                  = 0;
      rd_cd                     = 0;
      prev_cmd                  = 1'b0;
      prev_rd                   = 1'b0;
      waitrequest_from_bridge   = 1'b0;
      readdatavalid_from_bridge = 1'b0;
    end else begin
      // Settle the rising edge just passed.
      if (prev_cmd && !waitrequest_from_bridge) begin
        n_accept++;
        if (prev_rd && !knob_never && knob_lat > 0) rd_cd = knob_lat;
      end
      readdatavalid_from_bridge = 1'b0;
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) readdatavalid_from_bridge = 1'b1;
      end
      if (inject_rdv) readdatavalid_from_bridge = 1'b1;
      if (read_to_bridge || write_to_bridge) begin
        waitrequest_from_bridge = (hold_cnt < knob_wait);
        if (waitrequest_from_bridge) hold_cnt++;
        else hold_cnt = 0;
        if (read_to_bridge && !waitrequest_from_bridge && !knob_never && knob_lat == 0)
          readdatavalid_from_bridge = 1'b1;
      end else begin
        waitrequest_from_bridge = 1'b0;
        hold_cnt                = 0;
      end
      prev_cmd = read_to_bridge || write_to_bridge;
      prev_rd  = read_to_bridge;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;
  logic [63:0] last_rdata = '0;
  logic [64:0] exp_q[$];   // {err, rdata}

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL txn%0d %s observed=%0h expected=%0h", txn_id, tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [127:0] model_word(input logic [30:0] a, input logic [63:0] d,
                                              input logic [1:0] s);
    logic [127:0] w;
    w = 128'(a) + (128'(d) << 32);
    if (s == 2'd0) w = w + (128'd1 << 96);
    if (s == 2'd1) w = w + (128'd1 << 97);
    if (s == 2'd3) w = w + (128'd1 << 98);
    return w;
  endfunction

  function automatic bit model_mis(input logic [30:0] a, input logic [1:0] s);
    return (int'(a[2:0]) + (1 << s)) > 8;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [1:0] s,
                                             input bit sg);
    int          bits;
    logic [63:0] span;
    logic [63:0] m;
    bits = 8 << s;
    if (bits == 64) return rd;
    span = 64'd1 << bits;
    m = rd % span;
    if (sg && (m >= (span >> 1))) m = m - span;
    return m;
  endfunction

  // ---------------------------------------------------------------- driver
  // Entered just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input bit w, input logic [30:0] a, input logic [63:0] d,
                         input logic [1:0] s, input bit sg, input int wc, input int lat,
                         input bit never, input logic [127:0] rdw);
    bit           mis;
    bit           eerr;
    bit           got;
    int           natural;
    int           elat;
    int           estrobes;
    int           eacc;
    int           n;
    int           strobes;
    int           acc0;
    logic [127:0] ew;
    logic [63:0]  erd;
    logic [64:0]  exp_e;

    txn_id++;
    mis      = model_mis(a, s);
    ew       = model_word(a, d, s);
    natural  = w ? (2 + wc) : (never ? 1000000 : (2 + wc + lat));
    elat     = mis ? 1 : ((natural < TB_TIMEOUT) ? natural : TB_TIMEOUT);
    eerr     = mis || (natural > TB_TIMEOUT);
    erd      = (eerr || w) ? 64'd0 : model_load(rdw[63:0], s, sg);
    estrobes = mis ? 0 : (((1 + wc) < TB_TIMEOUT - 1) ? (1 + wc) : (TB_TIMEOUT - 1));
    eacc     = mis ? 0 : (((1 + wc) <= TB_TIMEOUT - 1) ? 1 : 0);
    exp_q.push_back({eerr, erd});

    knob_wait  = wc;
    knob_lat   = lat;
    knob_never = never;
    rd_word    = rdw;

    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before", 128'(req_ready), 128'(1));

    acc0       = n_accept;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_size   = s;
    req_signed = sg;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = 31'($urandom);
    req_wdata  = {$urandom, $urandom};

    n       = 1;
    got     = 1'b0;
    strobes = 0;
    while (!got && n <= 40) begin
      if (write_to_bridge || read_to_bridge) begin
        strobes++;
        check("cmd_word", writedata_to_bridge, ew);
        check("strobe_kind", 128'({write_to_bridge, read_to_bridge}), 128'({w, !w}));
        check("addr_zero", 128'(address_to_bridge), 128'(0));
      end
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("resp_seen", 128'(got), 128'(1));
    check("latency", 128'(n), 128'(elat));
    exp_e = exp_q.pop_front();
    check("resp_err", 128'(resp_err), 128'(exp_e[64]));
    check("resp_rdata", 128'(resp_rdata), 128'(exp_e[63:0]));
    check("strobe_cycles", 128'(strobes), 128'(estrobes));
    last_rdata = resp_rdata;

    @(negedge clk);
    #1;
    check("resp_single", 128'(resp_valid), 128'(0));
    check("ready_after", 128'(req_ready), 128'(1));
    check("bus_accepts", 128'(n_accept - acc0), 128'(eacc));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  bit           r_w;
  bit           r_sg;
  logic [1:0]   r_s;
  logic [30:0]  r_a;
  logic [63:0]  r_d;
  logic [127:0] r_rd;
  int           n_wait;

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_write", 128'(write_to_bridge), 128'(0));
    check("rst_read", 128'(read_to_bridge), 128'(0));
    check("rst_word", writedata_to_bridge, 128'(0));
    check("rst_rdata", 128'(resp_rdata), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("ready_out_of_reset", 128'(req_ready), 128'(1));

    // Byte store.
    run_txn(1'b1, 31'h0000_1003, 64'hAB, 2'd0, 1'b0, 0, 0, 1'b0, 128'd0);

    // Signed halfword load, one-cycle read latency.
    run_txn(1'b0, 31'h12, 64'h0, 2'd1, 1'b1, 0, 1, 1'b0,
            {64'hDEAD_BEEF_0BAD_F00D, 64'h1234_5678_9ABC_8001});
    check("shw_value", 128'(last_rdata), 128'(64'hFFFF_FFFF_FFFF_8001));

    // 64-bit store held off by five waitrequest cycles.
    run_txn(1'b1, 31'h100, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 5, 0, 1'b0, 128'd0);

    // Misaligned word access.
    run_txn(1'b0, 31'h6, 64'h0, 2'd2, 1'b0, 0, 1, 1'b0, 128'hFFFF);

    // Zero-latency read, unsigned byte.
    run_txn(1'b0, 31'h7FFF_FFF5, 64'h0, 2'd0, 1'b0, 0, 0, 1'b0, 128'h9_0000_00F3);

    // Store abandoned in CMD by the timeout.
    run_txn(1'b1, 31'h200, 64'h5555, 2'd2, 1'b0, 10, 0, 1'b0, 128'd0);

    // Load whose data never returns, then a stray readdatavalid in IDLE.
    run_txn(1'b0, 31'h300, 64'h0, 2'd2, 1'b1, 0, 0, 1'b1, 128'hFFFF_FFFF);
    @(posedge clk);
    #1 inject_rdv = 1'b1;
    @(posedge clk);
    #1 inject_rdv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rdv_no_resp", 128'(resp_valid), 128'(0));
    end
    check("late_rdv_ready", 128'(req_ready), 128'(1));

    // Reset while waiting for read data.
    txn_id++;
    knob_never = 1'b1;
    knob_wait  = 0;
    n_wait = 0;
    while (!req_ready && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 31'h40;
    req_size   = 2'd3;
    req_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_cmd_read", 128'(read_to_bridge), 128'(1));
    @(negedge clk);
    check("rw_wait_read_low", 128'(read_to_bridge), 128'(0));
    check("rw_wait_busy", 128'(req_ready), 128'(0));
    #1 reset = 1'b1;
    #1;
    check("rw_rst_read", 128'(read_to_bridge), 128'(0));
    check("rw_rst_write", 128'(write_to_bridge), 128'(0));
    check("rw_rst_resp", 128'({resp_valid, resp_err}), 128'(0));
    check("rw_rst_word", writedata_to_bridge, 128'(0));
    check("rw_rst_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rw_ready_after", 128'(req_ready), 128'(1));
    check("rw_no_resp", 128'(resp_valid), 128'(0));
    @(negedge clk);
    run_txn(1'b0, 31'h48, 64'h0, 2'd3, 1'b0, 1, 1, 1'b0,
            {$urandom, $urandom, $urandom, $urandom});

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      r_w  = 1'($urandom_range(0, 1));
      r_sg = 1'($urandom_range(0, 1));
      r_s  = 2'($urandom_range(0, 3));
      r_a  = 31'($urandom);
      if ($urandom_range(0, 3) != 0) r_a = (r_a >> r_s) << r_s;
      r_d  = {$urandom, $urandom};
      r_rd = {$urandom, $urandom, $urandom, $urandom};
      run_txn(r_w, r_a, r_d, r_s, r_sg, $urandom_range(0, 3), $urandom_range(0, 2),
              1'b0, r_rd);
    end

    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
